load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 12: data-memory word-address width.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before bus error.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  memory instruction present (memread|memwrite).
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  in  1  sign-extend loads when 1.
REQ-009 req_addr  in  32  byte address from ALU.
REQ-010 req_wdata  in  32  store data (rt).
REQ-011 stall  out  1  hold PC/pipeline while high.
REQ-012 load_data  out  32  extracted, extended load result.
REQ-013 load_valid  out  1  one-cycle pulse, load_data valid.
REQ-014 misaligned  out  1  one-cycle pulse, request rejected.
REQ-015 bus_error  out  1  one-cycle pulse, access timed out.
REQ-016 mem_en, mem_we  out  1 each  memory strobe, write enable.
REQ-017 mem_be  out  4  byte enables; mem_addr  out  ADDR_W; mem_wdata  out  32.
REQ-018 mem_rdata  in  32; mem_ready  in  1  memory completes access this cycle.

Function
REQ-019 FSM states IDLE, WAIT, DONE; little-endian byte lanes; lane = req_addr[1:0]; mem_addr = req_addr[ADDR_W+1:2].
REQ-020 Misaligned: size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11; in IDLE with req_valid, misaligned pulses same cycle (combinational), stall stays 0, no memory access, state stays IDLE.
REQ-021 IDLE, req_valid, aligned: capture write/size/signed/addr/wdata, stall=1 that cycle, next state WAIT, watchdog cleared to 0.
REQ-022 WAIT: mem_en=1, mem_we/mem_be/mem_addr/mem_wdata driven from captured registers only, stall=1, watchdog increments each cycle mem_ready=0.
REQ-023 Store steering: byte be=0001<<lane, wdata = byte replicated x4; half be=0011<<lane, wdata = halfword replicated x2; word be=1111; loads be=1111, mem_we=0.
REQ-024 WAIT with mem_ready=1: loads register extracted lane of mem_rdata, zero- or sign-extended per captured signed; next state DONE.
REQ-025 WAIT with mem_ready=0 and watchdog = TIMEOUT-1: next state DONE with error flag; mem_ready=1 in same cycle wins (normal completion, no error).
REQ-026 DONE: stall=0; load_valid=1 for successful load; bus_error=1 on timeout (load_data forced 0); next state IDLE; req_valid ignored in DONE.
REQ-027 Latency: aligned access with mem_ready in first WAIT cycle stalls exactly 2 cycles (IDLE, WAIT), result in third.
REQ-028 Outside WAIT, mem_en=0, mem_we=0, mem_be=0000; load_data holds last value until next load completes.

Reset
REQ-029 reset has priority over all inputs, including mid-WAIT: next state IDLE, watchdog 0, load_data 0, captured registers 0.
REQ-030 With reset high, stall, load_valid, misaligned, bus_error, mem_en, mem_we all 0 and mem_be 0000.

Structure
REQ-031 Shared package lsu_pkg holds the size encoding enum (SIZE_BYTE/HALF/WORD) and the state enum.
REQ-032 One combinational sub-module lsu_lane_align performs store lane steering/byte enables and load extraction/extension; FSM and watchdog stay in load_store_unit.

Verification
REQ-033 Store byte addr 0x0000_0006, wdata 0x0000_00AB, mem_ready 1st WAIT -> mem_addr 1, mem_be 0100, mem_wdata 0xABABABAB, stall 2 cycles.
REQ-034 Signed half load addr 0x12 with mem_rdata 0x8001_7FFF -> load_data 0xFFFF_8001, load_valid one cycle; unsigned -> 0x0000_8001.
REQ-035 Word load addr 0x5 -> misaligned pulse same cycle, stall 0, mem_en never asserted.
REQ-036 Load with mem_ready held 0, TIMEOUT=4 -> 4 WAIT cycles, bus_error pulse, load_data 0, return IDLE; repeat with mem_ready=1 on 4th WAIT cycle -> load_valid, no bus_error.
REQ-037 Reset asserted during WAIT -> next cycle IDLE, mem_en 0, stall 0, load_data 0; following word load addr 0x8 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access size, FSM state, alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store replication/byte enables, load extraction/extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        i_write,
  input  size_e       i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shift;
  logic [31:0] w_rshift;

  assign w_shift  = {i_lane, 3'b000};
  assign w_rshift = i_rdata >> w_shift;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = w_rshift;
    case (i_size)
      SIZE_BYTE: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_rshift[7]}}, w_rshift[7:0]};
        if (i_write) o_be = 4'b0001 << i_lane;
      end
      SIZE_HALF: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_rshift[15]}}, w_rshift[15:0]};
        if (i_write) o_be = 4'b0011 << i_lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/WAIT/DONE handshake with a word memory, watchdog-based bus error,
// pipeline stall generation and combinational misalignment rejection.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misaligned,
  output logic              bus_error,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              r_state, w_next;
  logic [WDOG_W-1:0]   r_wdog;
  logic                r_write;
  size_e               r_size;
  logic                r_signed;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_err;
  logic [31:0]         r_load_data;

  logic                w_mis;
  logic                w_accept;
  logic                w_timeout;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata_ext;
  logic                w_unused_addr;

  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  assign w_mis     = is_misaligned(req_size, req_addr[1:0]);
  assign w_accept  = (r_state == IDLE) && req_valid && !w_mis;
  assign w_timeout = (r_state == WAIT) && !mem_ready && (r_wdog == WDOG_W'(TIMEOUT - 1));

  // Memory-side steering works only from captured request fields
  lsu_lane_align u_align (
    .i_write  (r_write),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_lane   (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata_ext)
  );

  assign mem_addr  = r_addr[ADDR_W+1:2];
  assign mem_wdata = w_wdata;
  assign load_data = r_load_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wdog      <= '0;
      r_write     <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_accept) begin
          r_write  <= req_write;
          r_size   <= size_e'(req_size);
          r_signed <= req_signed;
          r_addr   <= req_addr[ADDR_W+1:0];
          r_wdata  <= req_wdata;
          r_wdog   <= '0;
          r_err    <= 1'b0;
        end
        WAIT: begin
          if (mem_ready) begin
            if (!r_write) r_load_data <= w_rdata_ext;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_load_data <= '0;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Reset masks every strobe, even while a WAIT is in flight
  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    misaligned = 1'b0;
    load_valid = 1'b0;
    bus_error  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    case (r_state)
      IDLE: if (w_accept) w_next = WAIT;
      WAIT: if (mem_ready || w_timeout) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (!reset) begin
      case (r_state)
        IDLE: begin
          stall      = req_valid && !w_mis;
          misaligned = req_valid && w_mis;
        end
        WAIT: begin
          stall  = 1'b1;
          mem_en = 1'b1;
          mem_we = r_write;
          mem_be = w_be;
        end
        DONE: begin
          load_valid = !r_write && !r_err;
          bus_error  = r_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-level memory model.
module tb_load_store_unit;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_write, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              stall, load_valid, misaligned, bus_error;
  logic [31:0]       load_data;
  logic              mem_en, mem_we, mem_ready;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] wmem    [16];
  logic [7:0]  ref_mem [64];
  logic [31:0] exp_ld;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_error(bus_error),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Word memory answering the DUT through its byte enables
  assign mem_rdata = wmem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we && mem_ready)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) wmem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request; rdy_at = WAIT cycle index at which mem_ready rises (>= TIMEOUT: never)
  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int rdy_at);
    int          nb;
    logic        mis, ok, fin;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    longint      raw;
    nb  = (sz == 2'd3) ? 8 : (1 << sz);
    mis = (sz == 2'd3) || ((a % nb) != 0);
    ebe = w ? 4'(((1 << nb) - 1) << a[1:0]) : 4'hF;
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % (nb > 4 ? 4 : nb)) +: 8];
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_misaligned", misaligned, mis);
    chk("idle_stall", stall, !mis);
    chk("idle_mem_en", mem_en, 0);
    if (mis) begin
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("mis_after_mem_en", mem_en, 0);
      chk("mis_after_stall", stall, 0);
      chk("mis_after_load_data", load_data, exp_ld);
      tick();
      return;
    end
    tick();
    ok = 1'b0; fin = 1'b0;
    for (int k = 0; k < TIMEOUT && !fin; k++) begin
      mem_ready = (k == rdy_at);
      @(negedge clk);
      chk("wait_mem_en", mem_en, 1);
      chk("wait_stall", stall, 1);
      chk("wait_mem_we", mem_we, w);
      chk("wait_mem_be", mem_be, ebe);
      chk("wait_mem_addr", mem_addr, a[13:2]);
      if (w) chk("wait_mem_wdata", mem_wdata, ewd);
      if (k == rdy_at) begin ok = 1'b1; fin = 1'b1; end
      else if (k == TIMEOUT - 1) fin = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    if (ok && w)
      for (int i = 0; i < nb; i++) ref_mem[(a[5:0] + i) % 64] = wd[8*i +: 8];
    if (ok && !w) begin
      raw = 0;
      for (int i = 0; i < nb; i++) raw = raw | (longint'(ref_mem[(a[5:0] + i) % 64]) << (8*i));
      if (sg && raw[8*nb-1]) raw = raw | ~((64'd1 << (8*nb)) - 1);
      exp_ld = raw[31:0];
    end
    if (!ok) exp_ld = 32'h0;
    @(negedge clk);
    chk("done_stall", stall, 0);
    chk("done_load_valid", load_valid, ok && !w);
    chk("done_bus_error", bus_error, !ok);
    chk("done_load_data", load_data, exp_ld);
    chk("done_mem_en", mem_en, 0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_mem_en", mem_en, 0);
    chk("idle_after_load_valid", load_valid, 0);
    chk("idle_after_load_data", load_data, exp_ld);
    tick();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          rdy;
    for (int wi = 0; wi < 16; wi++) begin
      wmem[wi] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*wi + b] = wmem[wi][8*b +: 8];
    end
    exp_ld = 32'h0;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11;
    req_signed = 1'b0; req_addr = 32'h5; req_wdata = 32'h0; mem_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_load_data", load_data, 0);
    tick();
    reset = 1'b0; req_valid = 1'b0;
    tick();

    // Byte store to lane 2 of word 1
    access(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00AB, 0);
    chk("byte_store_mem", wmem[1][23:16], 32'hAB);

    // Half loads from the upper half of 0x8001_7FFF
    access(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8001_7FFF, 0);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 0);
    chk("signed_half_value", load_data, 32'hFFFF_8001);
    access(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 0);
    chk("unsigned_half_value", load_data, 32'h0000_8001);

    // Misaligned word load
    access(1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0, 0);

    // Watchdog expiry, then ready arriving on the last permitted WAIT cycle
    access(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 99);
    chk("timeout_load_data", load_data, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, TIMEOUT - 1);

    // Reset in the middle of WAIT
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0024; mem_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("midwait_mem_en", mem_en, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_stall", stall, 0);
    chk("rst_wait_mem_en", mem_en, 0);
    chk("rst_wait_mem_be", mem_be, 0);
    tick();
    reset = 1'b0; req_valid = 1'b0;
    exp_ld = 32'h0;
    @(negedge clk);
    chk("post_rst_stall", stall, 0);
    chk("post_rst_mem_en", mem_en, 0);
    chk("post_rst_load_data", load_data, 0);
    tick();
    access(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 0);
    chk("post_rst_word_load", load_data, {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]});

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 2) != 0) sz = 2'd2;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~32'(((sz == 2'd3) ? 8 : (1 << sz)) - 1);
      rdy = ($urandom_range(0, 5) == 0) ? 9 : $urandom_range(0, TIMEOUT - 1);
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
